// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder
// -----------------------------------------------------------------------------
// Decodes RV32I OP / OP-IMM instructions into the ALU's opcode/op_0/op_1
// interface plus the writeback destination. Input and output each use a
// valid/ready handshake; a two-entry buffer (main + skid) absorbs one cycle
// of backpressure so nothing is lost or duplicated.
//
// Ports:
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake (in_ready is registered)
//   in_instr, in_rs1_val,   instruction word and its register operands
//   in_rs2_val
//   rs1_addr, rs2_addr      combinational register-file read addresses
//   out_valid/out_ready     downstream handshake
//   out_alu_opcode          000 ADD 001 SUB 010 AND 011 OR
//                           100 XOR 101 SLL 110 SRL 111 SRA
//   out_op_0, out_op_1      ALU operands
//   out_rd, out_rd_we       destination register and write enable
//   out_illegal             instruction not supported by this decoder
//   issue_count,            (only with ALU_ISSUE_STATS_EN defined) pop count
//   illegal_count           and illegal pop count, COUNT_WIDTH bits, wrapping
// -----------------------------------------------------------------------------
module alu_issue_decoder #(
   parameter int unsigned COUNT_WIDTH    = 16,
   parameter bit          SUPPRESS_X0_WE = 1'b1
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [31:0]            in_instr,
   input  logic [31:0]            in_rs1_val,
   input  logic [31:0]            in_rs2_val,
   output logic [4:0]             rs1_addr,
   output logic [4:0]             rs2_addr,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2:0]             out_alu_opcode,
   output logic [31:0]            out_op_0,
   output logic [31:0]            out_op_1,
   output logic [4:0]             out_rd,
   output logic                   out_rd_we,
   output logic                   out_illegal
`ifdef ALU_ISSUE_STATS_EN
   ,
   output logic [COUNT_WIDTH-1:0] issue_count,
   output logic [COUNT_WIDTH-1:0] illegal_count
`endif
);

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLL = 3'b101;
   localparam logic [2:0] ALU_SRL = 3'b110;
   localparam logic [2:0] ALU_SRA = 3'b111;

   localparam logic [6:0] MAJ_OP     = 7'b0110011;
   localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;

   typedef struct packed {
      logic [2:0]  opcode;
      logic [31:0] op_0;
      logic [31:0] op_1;
      logic [4:0]  rd;
      logic        rd_we;
      logic        illegal;
   } entry_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t state_q, state_d;
   entry_t main_q, main_d;
   entry_t skid_q, skid_d;
   logic   in_ready_q, in_ready_d;
   entry_t dec;

   logic accept;
   logic pop;

   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];

   // ---------------------------------------------------------------- decode
   always_comb begin
      logic [6:0] major;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       b5;
      logic       is_op;
      logic       is_imm;
      logic       legal;
      logic [2:0] alu;
      logic [31:0] op_1;

      major  = in_instr[6:0];
      f3     = in_instr[14:12];
      f7     = in_instr[31:25];
      b5     = in_instr[30];
      is_op  = (major == MAJ_OP);
      is_imm = (major == MAJ_OP_IMM);
      legal  = 1'b0;
      alu    = ALU_ADD;

      // Only funct7 0000000 / 0100000 exist for OP and immediate shifts; the
      // alternate form is meaningful only for SUB (OP) and SRA (both).
      case (f3)
         3'b000: begin
            alu   = (is_op && b5) ? ALU_SUB : ALU_ADD;
            legal = is_imm || (is_op && (f7 == 7'h00 || f7 == 7'h20));
         end
         3'b001: begin
            alu   = ALU_SLL;
            legal = (is_op || is_imm) && (f7 == 7'h00);
         end
         3'b100: begin
            alu   = ALU_XOR;
            legal = is_imm || (is_op && f7 == 7'h00);
         end
         3'b101: begin
            alu   = b5 ? ALU_SRA : ALU_SRL;
            legal = (is_op || is_imm) && (f7 == 7'h00 || f7 == 7'h20);
         end
         3'b110: begin
            alu   = ALU_OR;
            legal = is_imm || (is_op && f7 == 7'h00);
         end
         3'b111: begin
            alu   = ALU_AND;
            legal = is_imm || (is_op && f7 == 7'h00);
         end
         default: begin
            alu   = ALU_ADD;
            legal = 1'b0;
         end
      endcase

      if (is_op) begin
         op_1 = in_rs2_val;
      end else if (f3 == 3'b001 || f3 == 3'b101) begin
         op_1 = {27'd0, in_instr[24:20]};
      end else begin
         op_1 = {{20{in_instr[31]}}, in_instr[31:20]};
      end

      dec    = '0;
      dec.rd = in_instr[11:7];
      if (legal) begin
         dec.opcode = alu;
         dec.op_0   = in_rs1_val;
         dec.op_1   = op_1;
         dec.rd_we  = !(SUPPRESS_X0_WE && (in_instr[11:7] == 5'd0));
      end else begin
         dec.illegal = 1'b1;
      end
   end

   // ------------------------------------------------------- buffer control
   assign accept    = in_valid && in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = dec;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && pop) begin
               main_d = dec;
            end else if (accept) begin
               skid_d  = dec;
               state_d = ST_TWO;
            end else if (pop) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // in_ready is low here, so no accept can coincide with this pop
            if (pop) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
      in_ready_d = (state_d != ST_TWO);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_EMPTY;
         main_q     <= '0;
         skid_q     <= '0;
         in_ready_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
         in_ready_q <= in_ready_d;
      end
   end

   assign in_ready       = in_ready_q;
   assign out_alu_opcode = main_q.opcode;
   assign out_op_0       = main_q.op_0;
   assign out_op_1       = main_q.op_1;
   assign out_rd         = main_q.rd;
   assign out_rd_we      = main_q.rd_we;
   assign out_illegal    = main_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
   logic [COUNT_WIDTH-1:0] issue_count_q;
   logic [COUNT_WIDTH-1:0] illegal_count_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         issue_count_q   <= '0;
         illegal_count_q <= '0;
      end else if (pop) begin
         issue_count_q <= issue_count_q + COUNT_WIDTH'(1);
         if (main_q.illegal) begin
            illegal_count_q <= illegal_count_q + COUNT_WIDTH'(1);
         end
      end
   end

   assign issue_count   = issue_count_q;
   assign illegal_count = illegal_count_q;
`endif

endmodule

// File: doc/alu_issue_decoder.md
Name: alu_issue_decoder

Overview:
- Front end that drives the ALU's opcode/op_0/op_1 interface.
- Decodes RV32I OP (0110011) and OP-IMM (0010011) instructions into a 3-bit ALU operation code and two 32-bit operands, plus the writeback destination.
- Sits between fetch/register-read and the ALU.
- Accepts one instruction per cycle through a valid/ready handshake, with a 2-entry skid buffer so that backpressure never drops or duplicates an instruction.

Parameters:
- COUNT_WIDTH, 16: width of the optional statistics counters.
- SUPPRESS_X0_WE, 1: when 1, rd==0 forces out_rd_we=0.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream instruction valid.
- in_ready  output  1  decoder can accept.
- in_instr  input  32  RV32I instruction word.
- in_rs1_val  input  32  rs1 register value, aligned with in_instr.
- in_rs2_val  input  32  rs2 register value, aligned with in_instr.
- rs1_addr  output  5  in_instr[19:15], combinational, for register-file read.
- rs2_addr  output  5  in_instr[24:20], combinational.
- out_valid  output  1  decoded entry valid.
- out_ready  input  1  ALU stage accepts.
- out_alu_opcode  output  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- out_op_0  output  32  first ALU operand.
- out_op_1  output  32  second ALU operand.
- out_rd  output  5  destination register.
- out_rd_we  output  1  register write enable.
- out_illegal  output  1  instruction not supported.

Behaviour:
- Reset (reset_n low, asynchronous): buffer EMPTY; out_valid=0; in_ready=1; all data outputs 0. Applying reset mid-transfer discards both entries.
- Decode, funct3 = instr[14:12], funct7b5 = instr[30]:
  - 000: ADD; SUB only for OP with funct7b5=1.
  - 001: SLL.
  - 100: XOR.
  - 101: SRL, or SRA when funct7b5=1.
  - 110: OR.
  - 111: AND.
  - 010/011 (SLT/SLTU) and any other major opcode: out_illegal=1, opcode ADD, op_0=op_1=0, rd_we=0.
  - OP with instr[31:25] not in {0000000, 0100000}: illegal. Same for OP-IMM shifts with instr[31:25] not in {0000000, 0100000}, and for 0100000 combined with funct3 other than 000/101 (OP) or 101 (OP-IMM).
- Operands:
  - op_0 = in_rs1_val.
  - OP: op_1 = in_rs2_val.
  - OP-IMM: op_1 = sign-extended instr[31:20].
  - OP-IMM shifts: op_1 = zero-extended instr[24:20].
- rd = instr[11:7]. rd_we=1 for legal decodes, except rd==0 when SUPPRESS_X0_WE=1.
- Decode is combinational on input; the result is registered at the accept edge. Latency is 1 cycle from accept to out_valid.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: main register valid.
  - TWO: main and skid registers valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept without pop -> TWO; the new entry goes to skid.
  - ONE + pop without accept -> EMPTY.
  - ONE + accept and pop in the same cycle -> ONE, with main loaded from the new entry.
  - TWO + pop -> ONE, with skid moved to main.
- in_ready is a register equal to (next state != TWO). In TWO, in_ready=0 and input is ignored.
- Handshake rules:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - While out_valid=1 and out_ready=0, all out_* signals are held stable.
  - Strict in-order delivery, no loss, no duplication.

Optional Feature:
- Macro: ALU_ISSUE_STATS_EN.
- When defined, two extra output ports exist:
  - issue_count[COUNT_WIDTH-1:0]: increments on every pop.
  - illegal_count[COUNT_WIDTH-1:0]: increments on every pop with out_illegal=1.
- Both counters reset to 0 and wrap modulo 2^COUNT_WIDTH.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then instr 0x00500093 (addi x1,x0,5) with rs1_val=0 and out_ready=1 -> next cycle out_valid=1, opcode 000, op_0=0, op_1=5, rd=1, rd_we=1, illegal=0.
- R-type sub x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> opcode 001, op_0=10, op_1=3, rd=3. srai x4,x4,31 (0x41F25213) -> opcode 111, op_1=31.
- addi x5,x0,-1 (0xFFF00293) -> op_1=0xFFFFFFFF. slt (0x0020A1B3) -> illegal=1, rd_we=0, opcode 000, op_0=op_1=0.
- Hold out_ready=0 and present 3 back-to-back instructions -> 2 accepted, in_ready=0 in the cycle after the second accept, outputs stable. Then raise out_ready -> all 3 delivered in order on consecutive cycles.
- Assert reset_n low while in state TWO -> out_valid drops immediately (asynchronously); after release, in_ready=1 and no stale entry emerges.
- With ALU_ISSUE_STATS_EN and COUNT_WIDTH=4: 17 pops including 2 illegal -> issue_count=1 (wrapped), illegal_count=2.
